// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte
// (start, 8 data LSB first, odd parity, stop) on device clocks and checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic [3:0] state_dbg
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_RELEASE, S_SEND,
    S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t         state;
  logic           clk_s1, clk_s2, data_s1, data_s2;
  logic           clk_f, fall;
  logic [FW-1:0]  fcnt;
  logic [IW-1:0]  icnt;
  logic [TW-1:0]  tcnt;
  logic [3:0]     cnt;
  logic [10:0]    frame;
  logic           timed_out;

  assign rx_inhibit = tx_busy;
  assign state_dbg  = state;
  assign timed_out  = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Synchronizers plus a run-length glitch filter on the device clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      clk_f   <= 1'b1;
      fcnt    <= '0;
      fall    <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      if (clk_s2 == clk_f) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_s2;
        fcnt  <= '0;
        fall  <= ~clk_s2;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      tx_busy            <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      icnt               <= '0;
      tcnt               <= '0;
      cnt                <= '0;
      frame              <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            frame             <= {1'b1, ~^tx_data, tx_data, 1'b0};
            tx_busy           <= 1'b1;
            ps2_clk_drive_low <= 1'b1;
            icnt              <= '0;
            state             <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_data_drive_low <= ~frame[0];
            state              <= S_START;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        S_START: begin
          ps2_clk_drive_low <= 1'b0;
          state             <= S_RELEASE;
        end
        S_RELEASE: begin
          // The release cycle itself counts toward the first-edge timeout.
          tcnt  <= TW'(1);
          cnt   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (fall) begin
            ps2_data_drive_low <= ~frame[cnt + 4'd1];
            tcnt               <= TW'(1);
            if (cnt == 4'd9) state <= S_ACK;
            else             cnt   <= cnt + 4'd1;
          end else if (timed_out) begin
            ps2_data_drive_low <= 1'b0;
            tx_error           <= 1'b1;
            tx_busy            <= 1'b0;
            state              <= S_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_ACK: begin
          if ((fall && data_s2) || (!fall && timed_out)) begin
            tx_error <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= S_ERROR;
          end else if (fall) begin
            tcnt  <= TW'(1);
            state <= S_WAIT_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_f && data_s2) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= S_DONE;
          end else if (fall) begin
            tcnt <= TW'(1);
          end else if (timed_out) begin
            tx_error <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= S_ERROR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: begin
          ps2_clk_drive_low  <= 1'b0;
          ps2_data_drive_low <= 1'b0;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks the frame
// out, samples each bit on its rising edge and optionally ACKs.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic [3:0] state_dbg;
  logic       dev_clk, dev_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Open-drain bus: a line is low if either side pulls it low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(1000), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
  end

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic        glitch;
    logic [10:0] exp_frame;  // {stop, parity, d7..d0, start}
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_accept", {31'd0, tx_busy}, 32'd1);
    check("rx_inhibit_after_accept", {31'd0, rx_inhibit}, 32'd1);
  endtask

  task automatic dev_transfer(input logic do_ack, input logic glitch, input int rst_at,
                              output logic [10:0] bits);
    int lo_cnt = 0;
    int both_cnt = 0;
    bits = '0;
    while (ps2_clk_drive_low && lo_cnt < 200) begin
      lo_cnt++;
      if (ps2_data_drive_low) both_cnt++;
      @(negedge clk);
    end
    check("clk_inhibit_len", lo_cnt, 32'd21);
    check("start_bit_overlap", both_cnt, 32'd1);
    bits[0] = ps2_data_in;
    repeat (50) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      if (i == rst_at) begin
        repeat (25) @(negedge clk);
        check("data_driven_before_rst", {31'd0, ps2_data_drive_low}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_clk_drive", {31'd0, ps2_clk_drive_low}, 32'd0);
        check("rst_async_data_drive", {31'd0, ps2_data_drive_low}, 32'd0);
        check("rst_async_busy", {31'd0, tx_busy}, 32'd0);
        dev_clk = 1'b1;
        return;
      end
      repeat (50) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = ps2_data_in;
      if (glitch && i >= 3 && i <= 8) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (38) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
    end
    repeat (25) @(negedge clk);
    if (do_ack) dev_data = 1'b0;
    repeat (25) @(negedge clk);
    dev_clk = 1'b0;
    repeat (50) @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    for (int k = 0; k < 500 && tx_busy; k++) @(negedge clk);
    check("busy_released", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int d0, e0;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    send(v.data);
    dev_transfer(v.ack, v.glitch, -1, bits);
    if (bits !== v.exp_frame)
      $display("vector %0d data 0x%0h frame mismatch", idx, v.data);
    check("frame_bits", {21'd0, bits}, {21'd0, v.exp_frame});
    check("done_pulses", done_cnt - d0, v.exp_done);
    check("error_pulses", err_cnt - e0, v.exp_err);
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0, n;

    vecs[0] = '{8'hED, 1'b1, 1'b0, 11'b1_1_11101101_0, 1, 0};
    vecs[1] = '{8'hF4, 1'b1, 1'b0, 11'b1_0_11110100_0, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 11'b1_1_00000000_0, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 11'b1_1_11111111_0, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 11'b1_1_10100101_0, 0, 1};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 11'b1_1_00111100_0, 1, 0};

    rst = 1'b1; dev_clk = 1'b1; dev_data = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    check("rst_clk_drive", {31'd0, ps2_clk_drive_low}, 32'd0);
    check("rst_data_drive", {31'd0, ps2_data_drive_low}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_state", {28'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    // A second request while busy must be dropped without queueing.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    fork
      dev_transfer(1'b1, 1'b0, -1, bits);
      begin
        repeat (8) @(negedge clk);
        tx_data = 8'h11; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check("busy_ignore_frame", {21'd0, bits}, {21'd0, 11'b1_1_11101101_0});
    check("busy_ignore_done", done_cnt - d0, 32'd1);
    check("busy_ignore_error", err_cnt - e0, 32'd0);
    repeat (200) @(negedge clk);
    check("busy_ignore_no_requeue", {31'd0, tx_busy}, 32'd0);

    // Device never clocks: error exactly TIMEOUT_CYCLES after the clock release.
    e0 = err_cnt; d0 = done_cnt;
    send(8'hF4);
    for (int k = 0; k < 200 && ps2_clk_drive_low; k++) @(negedge clk);
    n = 0;
    while (!tx_error && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 32'd1000);
    @(negedge clk);
    check("timeout_clk_drive", {31'd0, ps2_clk_drive_low}, 32'd0);
    check("timeout_data_drive", {31'd0, ps2_data_drive_low}, 32'd0);
    check("timeout_error_pulses", err_cnt - e0, 32'd1);
    check("timeout_done_pulses", done_cnt - d0, 32'd0);
    repeat (3) @(negedge clk);
    run_vector(vecs[1], 1);

    // Reset during bit 4, then a clean transfer.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    dev_transfer(1'b1, 1'b0, 5, bits);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    check("rst_mid_no_error", err_cnt - e0, 32'd0);
    check("rst_mid_idle", {28'd0, state_dbg}, 32'd0);
    run_vector(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
